// File: rtl/flag_branch_ctrl.sv
// ---------------------------------------------------------------------------
// flag_branch_ctrl
//   Condition-flag and branch-resolution controller. Holds the architectural
//   NZCV register and counts in-flight flag-setting ops. It resolves B,
//   B.cond, CBZ and CBNZ. A B.cond stalls until every older flag write has
//   landed.
//
// Optional feature (compile-time macro): FLAG_FWD_EN
//   When defined, a B.cond waiting on the last outstanding flag write is
//   evaluated directly on wr_nzcv. This skips the EVAL cycle.
//
// Ports
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   iss_set_flags  in   flag-setting op enters EX (older than same-cycle branch)
//   iss_ready      out  low when MAX_PEND ops are outstanding
//   wr_valid       in   flag result write
//   wr_nzcv        in   {N,Z,C,V} for the write
//   br_req_valid   in   branch request from decode
//   br_req_ready   out  high only in IDLE
//   br_type        in   00 B, 01 B.cond, 10 CBZ, 11 CBNZ
//   br_cond        in   ARM condition code for B.cond
//   br_opnd_zero   in   register-operand zero bit for CBZ/CBNZ
//   br_done        out  one-cycle resolution pulse
//   br_taken       out  branch outcome, valid with br_done, else 0
//   stall          out  high while a B.cond waits (WAIT or EVAL)
//   nzcv           out  architectural flags
//   err            out  sticky protocol error
// ---------------------------------------------------------------------------
module flag_branch_ctrl #(
    parameter int unsigned MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iss_set_flags,
    output logic       iss_ready,
    input  logic       wr_valid,
    input  logic [3:0] wr_nzcv,
    input  logic       br_req_valid,
    output logic       br_req_ready,
    input  logic [1:0] br_type,
    input  logic [3:0] br_cond,
    input  logic       br_opnd_zero,
    output logic       br_done,
    output logic       br_taken,
    output logic       stall,
    output logic [3:0] nzcv,
    output logic       err
);

    localparam int unsigned PW = $clog2(MAX_PEND + 1);
    localparam logic [PW-1:0] MaxP = PW'(MAX_PEND);
    localparam logic [PW-1:0] OneP = PW'(1);

    typedef enum logic [1:0] {StIdle, StWait, StEval} state_t;

    state_t        r_state;
    logic [PW-1:0] r_pending;
    logic [3:0]    r_nzcv;
    logic [3:0]    r_cond;
    logic          r_br_done;
    logic          r_br_taken;
    logic          r_err;

    logic [PW-1:0] w_pend_next;
    logic          w_pend_zero;
    logic          w_pend_full;
    logic          w_nzcv_we;
    logic          w_err_set;
    logic          w_accept;
    logic          w_fwd_hit;

    // ARM condition evaluation. The odd codes invert the even ones, except
    // 1111 (NV), which is always taken, like AL.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic fn, fz, fc, fv, r;
        fn = f[3];
        fz = f[2];
        fc = f[1];
        fv = f[0];
        unique case (c[3:1])
            3'd0: r = fz;
            3'd1: r = fc;
            3'd2: r = fn;
            3'd3: r = fv;
            3'd4: r = fc & ~fz;
            3'd5: r = (fn == fv);
            3'd6: r = ~fz & (fn == fv);
            default: r = 1'b1;
        endcase
        if (c[0] && (c[3:1] != 3'd7)) begin
            r = ~r;
        end
        return r;
    endfunction

    assign w_pend_zero = (r_pending == '0);
    assign w_pend_full = (r_pending == MaxP);
    assign w_nzcv_we   = wr_valid & ~w_pend_zero;
    assign w_err_set   = (wr_valid & w_pend_zero) | (iss_set_flags & w_pend_full);
    assign w_accept    = br_req_valid & (r_state == StIdle);

    // Saturating counter: an issue and a write in the same cycle cancel each other.
    always_comb begin
        w_pend_next = r_pending;
        if (iss_set_flags && !wr_valid) begin
            if (!w_pend_full) w_pend_next = r_pending + OneP;
        end else if (wr_valid && !iss_set_flags) begin
            if (!w_pend_zero) w_pend_next = r_pending - OneP;
        end
    end

`ifdef FLAG_FWD_EN
    // The last outstanding write lands this cycle, and no younger op is issuing.
    assign w_fwd_hit = wr_valid & ~iss_set_flags & (r_pending == OneP);
`else
    assign w_fwd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_nzcv    <= 4'b0000;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            if (w_nzcv_we) r_nzcv <= wr_nzcv;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_cond     <= 4'b0000;
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        unique case (br_type)
                            2'b00: begin
                                r_br_done  <= 1'b1;
                                r_br_taken <= 1'b1;
                            end
                            2'b01: begin
                                if (w_pend_zero && !iss_set_flags && !wr_valid) begin
                                    r_br_done  <= 1'b1;
                                    r_br_taken <= cond_eval(br_cond, r_nzcv);
                                end else if (w_fwd_hit) begin
                                    r_br_done  <= 1'b1;
                                    r_br_taken <= cond_eval(br_cond, wr_nzcv);
                                end else begin
                                    r_cond  <= br_cond;
                                    r_state <= StWait;
                                end
                            end
                            2'b10: begin
                                r_br_done  <= 1'b1;
                                r_br_taken <= br_opnd_zero;
                            end
                            2'b11: begin
                                r_br_done  <= 1'b1;
                                r_br_taken <= ~br_opnd_zero;
                            end
                            default: ;
                        endcase
                    end
                end
                StWait: begin
                    if (w_fwd_hit) begin
                        r_br_done  <= 1'b1;
                        r_br_taken <= cond_eval(r_cond, wr_nzcv);
                        r_state    <= StIdle;
                    end else if (w_pend_next == '0) begin
                        r_state <= StEval;
                    end
                end
                StEval: begin
                    r_br_done  <= 1'b1;
                    r_br_taken <= cond_eval(r_cond, r_nzcv);
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign iss_ready    = ~w_pend_full;
    assign br_req_ready = (r_state == StIdle);
    assign stall        = (r_state != StIdle);
    assign br_done      = r_br_done;
    assign br_taken     = r_br_taken;
    assign nzcv         = r_nzcv;
    assign err          = r_err;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
module tb_flag_branch_ctrl;

    logic       clk;
    logic       reset_n;
    logic       iss_set_flags;
    logic       iss_ready;
    logic       wr_valid;
    logic [3:0] wr_nzcv;
    logic       br_req_valid;
    logic       br_req_ready;
    logic [1:0] br_type;
    logic [3:0] br_cond;
    logic       br_opnd_zero;
    logic       br_done;
    logic       br_taken;
    logic       stall;
    logic [3:0] nzcv;
    logic       err;

    int checks;
    int failures;
    logic [15:0] sweep_exp;

    flag_branch_ctrl #(.MAX_PEND(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .iss_set_flags(iss_set_flags),
        .iss_ready    (iss_ready),
        .wr_valid     (wr_valid),
        .wr_nzcv      (wr_nzcv),
        .br_req_valid (br_req_valid),
        .br_req_ready (br_req_ready),
        .br_type      (br_type),
        .br_cond      (br_cond),
        .br_opnd_zero (br_opnd_zero),
        .br_done      (br_done),
        .br_taken     (br_taken),
        .stall        (stall),
        .nzcv         (nzcv),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_set_flags = 1'b0;
        wr_valid      = 1'b0;
        wr_nzcv       = 4'b0000;
        br_req_valid  = 1'b0;
        br_type       = 2'b00;
        br_cond       = 4'b0000;
        br_opnd_zero  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_nzcv", nzcv, 8'h0);
        chk("rst_stall", stall, 8'h0);
        chk("rst_ready", br_req_ready, 8'h1);
        chk("rst_iss_ready", iss_ready, 8'h1);
        chk("rst_err", err, 8'h0);
        chk("rst_done", br_done, 8'h0);
        #2 reset_n = 1'b1;
        tick();

        // Non-dependent branches, issued back to back
        br_req_valid = 1'b1; br_type = 2'b10; br_opnd_zero = 1'b1;
        tick();
        chk("cbz1_done", br_done, 8'h1);
        chk("cbz1_taken", br_taken, 8'h1);
        br_type = 2'b11;
        tick();
        chk("cbnz1_done", br_done, 8'h1);
        chk("cbnz1_taken", br_taken, 8'h0);
        br_type = 2'b00; br_opnd_zero = 1'b0;
        tick();
        chk("b_done", br_done, 8'h1);
        chk("b_taken", br_taken, 8'h1);
        br_type = 2'b10;
        tick();
        chk("cbz0_taken", br_taken, 8'h0);
        br_type = 2'b11;
        tick();
        chk("cbnz0_taken", br_taken, 8'h1);
        idle_inputs();
        tick();
        chk("pulse_end_done", br_done, 8'h0);
        chk("pulse_end_taken", br_taken, 8'h0);

        // Dependent B.cond EQ: the issue and the branch in t0, the write in t3
        iss_set_flags = 1'b1; br_req_valid = 1'b1; br_type = 2'b01; br_cond = 4'b0000;
        tick();
        idle_inputs();
        chk("haz_t1_stall", stall, 8'h1);
        chk("haz_t1_ready", br_req_ready, 8'h0);
        chk("haz_t1_done", br_done, 8'h0);
        tick();
        chk("haz_t2_stall", stall, 8'h1);
        tick();
        chk("haz_t3_stall", stall, 8'h1);
        wr_valid = 1'b1; wr_nzcv = 4'b0100;
        tick();
        idle_inputs();
        chk("haz_t4_nzcv", nzcv, 8'h4);
`ifdef FLAG_FWD_EN
        chk("haz_t4_stall", stall, 8'h0);
        chk("haz_t4_done", br_done, 8'h1);
        chk("haz_t4_taken", br_taken, 8'h1);
        tick();
        chk("haz_t5_done", br_done, 8'h0);
`else
        chk("haz_t4_stall", stall, 8'h1);
        chk("haz_t4_done", br_done, 8'h0);
        tick();
        chk("haz_t5_stall", stall, 8'h0);
        chk("haz_t5_done", br_done, 8'h1);
        chk("haz_t5_taken", br_taken, 8'h1);
`endif

        // Reset in the middle of WAIT: the aborted branch never resolves
        iss_set_flags = 1'b1; br_req_valid = 1'b1; br_type = 2'b01; br_cond = 4'b0001;
        tick();
        idle_inputs();
        chk("rw_stall", stall, 8'h1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rw_nzcv", nzcv, 8'h0);
        chk("rw_stall0", stall, 8'h0);
        chk("rw_ready", br_req_ready, 8'h1);
        chk("rw_err", err, 8'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rw_no_done", br_done, 8'h0);
        end

        // Condition sweep with NZCV = 1001
        iss_set_flags = 1'b1;
        tick();
        iss_set_flags = 1'b0; wr_valid = 1'b1; wr_nzcv = 4'b1001;
        tick();
        idle_inputs();
        chk("sw_nzcv", nzcv, 8'h9);
        sweep_exp = 16'hD65A;
        for (int c = 0; c < 16; c++) begin
            br_req_valid = 1'b1; br_type = 2'b01; br_cond = 4'(c);
            tick();
            chk($sformatf("sw_done_%0d", c), br_done, 8'h1);
            chk($sformatf("sw_taken_%0d", c), br_taken, {7'b0, sweep_exp[c]});
        end
        idle_inputs();
        tick();

        // Saturation at MAX_PEND
        iss_set_flags = 1'b1;
        tick();
        tick();
        chk("sat_ready2", iss_ready, 8'h1);
        tick();
        chk("sat_ready3", iss_ready, 8'h0);
        chk("sat_err_before", err, 8'h0);
        tick();
        chk("sat_err", err, 8'h1);
        chk("sat_ready4", iss_ready, 8'h0);
        iss_set_flags = 1'b0; wr_valid = 1'b1; wr_nzcv = 4'b0011;
        tick();
        chk("sat_wr1", nzcv, 8'h3);
        chk("sat_ready_wr1", iss_ready, 8'h1);
        wr_nzcv = 4'b1100;
        tick();
        wr_nzcv = 4'b0110;
        tick();
        idle_inputs();
        chk("sat_nzcv_last", nzcv, 8'h6);
        // Pending is zero, so this B.cond EQ resolves at once (Z=1)
        br_req_valid = 1'b1; br_type = 2'b01; br_cond = 4'b0000;
        tick();
        idle_inputs();
        chk("sat_bcond_done", br_done, 8'h1);
        chk("sat_bcond_taken", br_taken, 8'h1);
        chk("sat_bcond_stall", stall, 8'h0);

        // A write with nothing pending is dropped and raises err
        do_reset();
        chk("drop_err_clr", err, 8'h0);
        wr_valid = 1'b1; wr_nzcv = 4'b1111;
        tick();
        idle_inputs();
        chk("drop_nzcv", nzcv, 8'h0);
        chk("drop_err", err, 8'h1);
        tick();
        chk("drop_err_sticky", err, 8'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
